// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU arbiter: opcodes, FSM states and
// a small helper that turns a requester index into a one-hot accept vector.
package alu_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ADD  = 3'd6,
        OP_SUB  = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
        req_onehot = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, one consumer and the arbiter.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid never waits on ready, and a payload is held stable while valid is high.
interface alu_arbiter_if #(
    parameter int WIDTH = 8
) ();

    logic [alu_pkg::NUM_REQ-1:0]             req_valid;
    logic [alu_pkg::NUM_REQ-1:0]             req_ready;
    alu_pkg::alu_op_t [alu_pkg::NUM_REQ-1:0] req_op;
    logic [alu_pkg::NUM_REQ-1:0][WIDTH-1:0]  req_a;
    logic [alu_pkg::NUM_REQ-1:0][WIDTH-1:0]  req_b;
    logic                                    rsp_valid;
    logic                                    rsp_ready;
    logic [WIDTH-1:0]                        rsp_data;
    logic                                    rsp_id;
    logic                                    rsp_carry;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_carry
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_carry
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: eight bitwise/arithmetic ops with a carry flag
// that is meaningful only for ADD (carry out) and SUB (no-borrow).
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_op_t          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o
);

    logic [WIDTH-1:0] or_w;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_or
        alu_or_bit u_or_bit (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .y_o (or_w[i])
        );
    end

    assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
    // a + ~b + 1 carries out of the top bit exactly when a >= b (no borrow).
    assign diff_w = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            OP_AND:  result_o = a_i & b_i;
            OP_NAND: result_o = ~(a_i & b_i);
            OP_OR:   result_o = or_w;
            OP_NOR:  result_o = ~or_w;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_XNOR: result_o = ~(a_i ^ b_i);
            OP_ADD: begin
                result_o = sum_w[WIDTH-1:0];
                carry_o  = sum_w[WIDTH];
            end
            OP_SUB: begin
                result_o = diff_w[WIDTH-1:0];
                carry_o  = diff_w[WIDTH];
            end
            default: begin
                result_o = '0;
                carry_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_or_bit.sv
// Single-bit OR cell; the ALU's OR and NOR paths are built from a row of these.
module alu_or_bit (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    assign y_o = a_i | b_i;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a shared ALU: IDLE accepts one request, EXEC
// computes and registers the result, RESP holds it until the consumer takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_arbiter_if.slave bus,
    output arb_state_t  dbg_state_o
);

    arb_state_t       state_q, state_d;
    logic             last_q, last_d;
    alu_op_t          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_id_q, rsp_id_d;

    logic             grant_w;
    logic [1:0]       req_ready_w;
    logic [WIDTH-1:0] alu_result_w;
    logic             alu_carry_w;

    // With both requesting, favour the one not served last; otherwise take whoever asks.
    always_comb begin
        grant_w = 1'b0;
        if (&bus.req_valid) begin
            grant_w = ~last_q;
        end else begin
            grant_w = ~bus.req_valid[0];
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_result_w),
        .carry_o  (alu_carry_w)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_id_d    = rsp_id_q;
        req_ready_w = 2'b00;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    req_ready_w = req_onehot(grant_w);
                    op_d        = bus.req_op[grant_w];
                    a_d         = bus.req_a[grant_w];
                    b_d         = bus.req_b[grant_w];
                    id_d        = grant_w;
                    last_d      = grant_w;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_result_w;
                rsp_carry_d = alu_carry_w;
                rsp_id_d    = id_q;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            op_q        <= OP_AND;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // rsp_valid is decoded from state so an asynchronous reset drops it at once.
    assign bus.req_ready = req_ready_w;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.rsp_id    = rsp_id_q;
    assign dbg_state_o   = state_q;

endmodule
